// File: rtl/switch_debounce.sv
// Input conditioner: synchronises and debounces six raw board inputs onto sysclk,
// and produces a one-cycle strobe when the debounced write level rises.
module switch_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned CNT_W           = 17
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic sw1_in,
    input  logic sw2_in,
    input  logic sw3_in,
    input  logic sw4_in,
    input  logic write_in,
    input  logic auto_in,
    output logic sw1,
    output logic sw2,
    output logic sw3,
    output logic sw4,
    output logic write,
    output logic write_pulse,
    output logic auto
);

    localparam int NCh = 6;
    localparam int ChWrite = 4;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NCh-1:0] raw;
    logic [NCh-1:0] s0_q;
    logic [NCh-1:0] s1_q;
    logic [NCh-1:0] st_q;
    logic [NCh-1:0] st_d;
    logic [CNT_W-1:0] cnt_q [NCh];
    logic [CNT_W-1:0] cnt_d [NCh];
    logic pulse_q;
    logic pulse_d;

    assign raw = {auto_in, write_in, sw4_in, sw3_in, sw2_in, sw1_in};

    // Any sample equal to the stable level clears the count: no partial credit.
    always_comb begin
        for (int i = 0; i < NCh; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = '0;
            if (s1_q[i] != st_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    st_d[i] = s1_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        pulse_d = st_d[ChWrite] & ~st_q[ChWrite];
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            s0_q    <= '0;
            s1_q    <= '0;
            st_q    <= '0;
            pulse_q <= 1'b0;
            for (int i = 0; i < NCh; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s0_q    <= raw;
            s1_q    <= s0_q;
            st_q    <= st_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < NCh; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw1         = st_q[0];
    assign sw2         = st_q[1];
    assign sw3         = st_q[2];
    assign sw4         = st_q[3];
    assign write       = st_q[ChWrite];
    assign auto        = st_q[5];
    assign write_pulse = pulse_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with a short debounce window (16 cycles -> 18-edge latency).
module tb_switch_debounce;

    localparam int unsigned Deb = 16;
    localparam int Lat = 18;

    logic sysclk = 1'b0;
    logic rst_n;
    logic sw1_in, sw2_in, sw3_in, sw4_in, write_in, auto_in;
    logic sw1, sw2, sw3, sw4, write, write_pulse, auto;

    int n_checks = 0;
    int n_fail = 0;
    int pulses;

    always #5 sysclk = ~sysclk;

    switch_debounce #(
        .DEBOUNCE_CYCLES(Deb),
        .CNT_W          (5)
    ) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .sw1_in     (sw1_in),
        .sw2_in     (sw2_in),
        .sw3_in     (sw3_in),
        .sw4_in     (sw4_in),
        .write_in   (write_in),
        .auto_in    (auto_in),
        .sw1        (sw1),
        .sw2        (sw2),
        .sw3        (sw3),
        .sw4        (sw4),
        .write      (write),
        .write_pulse(write_pulse),
        .auto       (auto)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and land 1 time unit after it, away from the active edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    function automatic logic [6:0] outs();
        return {auto, write_pulse, write, sw4, sw3, sw2, sw1};
    endfunction

    initial begin
        // 1. Reset with all inputs high
        rst_n = 1'b0;
        {sw1_in, sw2_in, sw3_in, sw4_in, write_in, auto_in} = 6'h3f;
        step(4);
        check_eq("reset_outs", 32'(outs()), 32'h0);
        rst_n = 1'b1;
        step(Lat - 1);
        check_eq("rel_pre", 32'(outs()), 32'h0);
        step(1);
        check_eq("rel_levels", 32'(outs()), 32'h7f);
        step(1);
        check_eq("rel_pulse_end", 32'(write_pulse), 32'h0);

        // 4. Release of write: no pulse on the falling edge
        write_in = 1'b0;
        pulses = 0;
        for (int k = 1; k <= Lat; k++) begin
            step(1);
            pulses += int'(write_pulse);
            if (k == Lat - 1) check_eq("wr_fall_pre", 32'(write), 32'h1);
        end
        check_eq("wr_fall", 32'(write), 32'h0);
        check_eq("wr_fall_nopulse", 32'(pulses), 32'h0);

        // 2. Clean press held 40 cycles
        write_in = 1'b1;
        step(Lat - 1);
        check_eq("wr_rise_pre", 32'({write, write_pulse}), 32'h0);
        step(1);
        check_eq("wr_rise", 32'({write, write_pulse}), 32'h3);
        pulses = 0;
        for (int k = 0; k < 40 - Lat; k++) begin
            step(1);
            pulses += int'(write_pulse);
        end
        check_eq("wr_held_level", 32'(write), 32'h1);
        check_eq("wr_held_nopulse", 32'(pulses), 32'h0);

        // 3. Bounce on sw1: bring low, then toggle every 5 cycles for 60 cycles
        sw1_in = 1'b0;
        step(Lat + 2);
        check_eq("sw1_low", 32'(sw1), 32'h0);
        pulses = 0;
        for (int seg = 0; seg < 12; seg++) begin
            sw1_in = (seg % 2 == 0);
            for (int k = 0; k < 5; k++) begin
                step(1);
                pulses += int'(sw1);
            end
        end
        check_eq("sw1_bounce_quiet", 32'(pulses), 32'h0);
        sw1_in = 1'b1;
        step(Lat - 1);
        check_eq("sw1_settle_pre", 32'(sw1), 32'h0);
        step(1);
        check_eq("sw1_settle", 32'(sw1), 32'h1);

        // 5. Simultaneous edges on sw2 and auto
        sw2_in = 1'b0;
        auto_in = 1'b0;
        step(Lat + 2);
        check_eq("sw2_auto_low", 32'({sw2, auto}), 32'h0);
        sw2_in = 1'b1;
        auto_in = 1'b1;
        pulses = 0;
        for (int k = 1; k <= Lat; k++) begin
            step(1);
            if (sw2 != auto) pulses++;
            if (k == Lat - 1) check_eq("simul_pre", 32'({sw2, auto}), 32'h0);
        end
        check_eq("simul_lockstep", 32'(pulses), 32'h0);
        check_eq("simul_rise", 32'({sw2, auto}), 32'h3);
        check_eq("simul_others", 32'({sw1, sw3, sw4}), 32'h7);

        // 6. Reset while sw3 is mid-count (cnt = 10 after 12 edges)
        sw3_in = 1'b0;
        step(Lat + 2);
        check_eq("sw3_low", 32'(sw3), 32'h0);
        sw3_in = 1'b1;
        step(12);
        check_eq("sw3_midcount", 32'(sw3), 32'h0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_clear", 32'(outs()), 32'h0);
        step(3);
        check_eq("midrst_hold", 32'(outs()), 32'h0);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 1; k < Lat; k++) begin
            step(1);
            pulses += int'(sw3);
        end
        check_eq("midrst_requal_pre", 32'(pulses), 32'h0);
        step(1);
        check_eq("midrst_sw3", 32'(sw3), 32'h1);
        check_eq("midrst_all", 32'(outs()), 32'h7f);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
